// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit ALU command issuer: opcodes, instruction
// field positions, FSM state encoding and response error code.
package alu4_pkg;

    // Opcodes carried in cmd_data[11:9]
    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_SHIFT   = 3'b010;
    localparam logic [2:0] OP_MUL     = 3'b011;
    localparam logic [2:0] OP_XNOR    = 3'b100;
    localparam logic [2:0] OP_CMP     = 3'b101;
    localparam logic [2:0] OP_LOAD    = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    // Instruction field positions
    localparam int CMD_OP_MSB  = 11;
    localparam int CMD_OP_LSB  = 9;
    localparam int CMD_RD_MSB  = 8;
    localparam int CMD_RD_LSB  = 7;
    localparam int CMD_RA_MSB  = 6;
    localparam int CMD_RA_LSB  = 5;
    localparam int CMD_RB_MSB  = 4;
    localparam int CMD_RB_LSB  = 3;
    localparam int CMD_CIN     = 2;
    localparam int CMD_IMM_MSB = 6;
    localparam int CMD_IMM_LSB = 3;

    // FSM state encoding (2 bits)
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ISSUE = 2'b01;
    localparam logic [1:0] ST_WAIT  = 2'b10;
    localparam logic [1:0] ST_RESP  = 2'b11;

    // Value of rsp_err reported for an illegal opcode
    localparam logic RSP_ERR_ILLEGAL = 1'b1;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] ra;
        logic [1:0] rb;
        logic       cin;
        logic [3:0] imm;
    } cmd_fields_t;

    // Split a raw instruction word into its fields; imm overlaps ra/rb.
    function automatic cmd_fields_t decode_cmd(input logic [11:0] word);
        cmd_fields_t f;
        f.op  = word[CMD_OP_MSB:CMD_OP_LSB];
        f.rd  = word[CMD_RD_MSB:CMD_RD_LSB];
        f.ra  = word[CMD_RA_MSB:CMD_RA_LSB];
        f.rb  = word[CMD_RB_MSB:CMD_RB_LSB];
        f.cin = word[CMD_CIN];
        f.imm = word[CMD_IMM_MSB:CMD_IMM_LSB];
        return f;
    endfunction

endpackage

// File: rtl/alu4_regfile.sv
// 4x4-bit register file: two asynchronous read ports, one synchronous write
// port, synchronous active-low clear.
module alu4_regfile
    import alu4_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       we_i,
    input  logic [1:0] waddr_i,
    input  logic [3:0] wdata_i,
    input  logic [1:0] raddr_a_i,
    output logic [3:0] rdata_a_o,
    input  logic [1:0] raddr_b_i,
    output logic [3:0] rdata_b_o
);

    logic [3:0] regs_q [DEPTH];

    // Clear all entries on reset, otherwise perform the single write
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= 4'h0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/alu4_cmd_issuer.sv
// Initiator for the external ALU4 datapath: takes instructions on a
// valid/ready channel, issues operands, waits ALU_LAT cycles, writes the low
// nibble back and returns the full result byte on a valid/ready channel.
module alu4_cmd_issuer
    import alu4_pkg::*;
#(
    parameter int ALU_LAT = 2,
    parameter int NREGS   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [11:0] cmd_data,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic        alu_cin,
    output logic [2:0]  alu_op,
    input  logic [7:0]  alu_out,
    input  logic        alu_cout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_cout,
    output logic        rsp_err,
    output logic        busy
);

    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    cmd_fields_t cmd_f;
    logic        unused_cmd_bits;

    logic [1:0]       state_q, state_d;
    logic [1:0]       rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
    logic             cin_q, cin_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic             alu_cin_q, alu_cin_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             rsp_cout_q, rsp_cout_d, rsp_err_q, rsp_err_d;

    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [3:0] rf_wdata, rf_rdata_a, rf_rdata_b;

    assign cmd_f           = decode_cmd(cmd_data);
    assign unused_cmd_bits = ^cmd_data[1:0];

    alu4_regfile #(.DEPTH(NREGS)) u_regfile (
        .clk       (clk),
        .reset_n   (reset_n),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_a_i (ra_q),
        .rdata_a_o (rf_rdata_a),
        .raddr_b_i (rb_q),
        .rdata_b_o (rf_rdata_b)
    );

    // Next-state, datapath capture and the single regfile write port
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        cin_d      = cin_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_cin_d  = alu_cin_q;
        alu_op_d   = alu_op_q;
        rsp_data_d = rsp_data_q;
        rsp_cout_d = rsp_cout_q;
        rsp_err_d  = rsp_err_q;
        rf_we      = 1'b0;
        rf_waddr   = rd_q;
        rf_wdata   = 4'h0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    rd_d  = cmd_f.rd;
                    ra_d  = cmd_f.ra;
                    rb_d  = cmd_f.rb;
                    cin_d = cmd_f.cin;
                    op_d  = cmd_f.op;
                    if (cmd_f.op == OP_LOAD) begin
                        // LOAD bypasses the ALU and writes the immediate now
                        rf_we      = 1'b1;
                        rf_waddr   = cmd_f.rd;
                        rf_wdata   = cmd_f.imm;
                        rsp_data_d = {4'h0, cmd_f.imm};
                        rsp_cout_d = 1'b0;
                        rsp_err_d  = 1'b0;
                        state_d    = ST_RESP;
                    end else if (cmd_f.op == OP_ILLEGAL) begin
                        rsp_data_d = 8'h00;
                        rsp_cout_d = 1'b0;
                        rsp_err_d  = RSP_ERR_ILLEGAL;
                        state_d    = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // Operands are read here so they see any earlier write-back
                alu_a_d   = rf_rdata_a;
                alu_b_d   = rf_rdata_b;
                alu_cin_d = cin_q;
                alu_op_d  = op_q;
                cnt_d     = CNT_W'(ALU_LAT - 1);
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d = alu_out;
                    rsp_cout_d = alu_cout;
                    rsp_err_d  = 1'b0;
                    rf_we      = 1'b1;
                    rf_wdata   = alu_out[3:0];
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State and output registers; reset discards any op in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rd_q       <= 2'd0;
            ra_q       <= 2'd0;
            rb_q       <= 2'd0;
            cin_q      <= 1'b0;
            op_q       <= 3'd0;
            cnt_q      <= '0;
            alu_a_q    <= 4'h0;
            alu_b_q    <= 4'h0;
            alu_cin_q  <= 1'b0;
            alu_op_q   <= 3'd0;
            rsp_data_q <= 8'h00;
            rsp_cout_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            cin_q      <= cin_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_cin_q  <= alu_cin_d;
            alu_op_q   <= alu_op_d;
            rsp_data_q <= rsp_data_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_err   = rsp_err_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cin   = alu_cin_q;
    assign alu_op    = alu_op_q;

endmodule
